// File: rtl/my_pkg.sv
// Shared definitions for the load/store sequencer: memory access encodings,
// sequencer state type and small decode helpers.
package my_pkg;

    localparam int DATA_WIDTH = 32;

    // Access format encodings as driven by the decoder (stores reuse B/H/W).
    localparam logic [2:0] MEM_OP_B  = 3'b001;
    localparam logic [2:0] MEM_OP_H  = 3'b010;
    localparam logic [2:0] MEM_OP_W  = 3'b011;
    localparam logic [2:0] MEM_OP_BU = 3'b101;
    localparam logic [2:0] MEM_OP_HU = 3'b110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ0 = 3'd1,
        ST_RSP0 = 3'd2,
        ST_REQ1 = 3'd3,
        ST_RSP1 = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_e;

    // True for the five access formats the sequencer will execute.
    function automatic logic op_is_legal(input logic [2:0] op);
        logic legal;
        case (op)
            MEM_OP_B, MEM_OP_H, MEM_OP_W, MEM_OP_BU, MEM_OP_HU: legal = 1'b1;
            default:                                            legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Unshifted byte mask for the access size (low two bits select size).
    function automatic logic [3:0] op_size_mask(input logic [2:0] op);
        logic [3:0] mask;
        case (op[1:0])
            2'b01:   mask = 4'b0001;
            2'b10:   mask = 4'b0011;
            2'b11:   mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: byte enables for both beats, store data lane
// shifting, and load byte extraction with sign/zero extension.
module rv_lsu_align #(
    parameter int DATA_WIDTH = my_pkg::DATA_WIDTH
) (
    input  logic [2:0]            op_i,
    input  logic [1:0]            off_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata0_i,
    input  logic [DATA_WIDTH-1:0] rdata1_i,
    output logic                  split_o,
    output logic [3:0]            be0_o,
    output logic [3:0]            be1_o,
    output logic [DATA_WIDTH-1:0] wdata0_o,
    output logic [DATA_WIDTH-1:0] wdata1_o,
    output logic [DATA_WIDTH-1:0] ldata_o
);
    import my_pkg::*;

    logic [7:0]              mask_s;
    logic [2*DATA_WIDTH-1:0] wide_w_s;
    logic [DATA_WIDTH-1:0]   win_s;

    // Shift the size mask and store data across an 8-byte window spanning
    // both beats; bytes that spill past lane 3 belong to the second beat.
    always_comb begin
        mask_s   = {4'b0000, op_size_mask(op_i)} << off_i;
        split_o  = |mask_s[7:4];
        be0_o    = mask_s[3:0];
        be1_o    = mask_s[7:4];
        wide_w_s = {{DATA_WIDTH{1'b0}}, wdata_i} << {off_i, 3'b000};
        wdata0_o = wide_w_s[DATA_WIDTH-1:0];
        wdata1_o = wide_w_s[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // Right-align the addressed bytes from the two read words, then extend.
    always_comb begin
        win_s = DATA_WIDTH'({rdata1_i, rdata0_i} >> {off_i, 3'b000});
        case (op_i)
            MEM_OP_B:  ldata_o = {{(DATA_WIDTH-8){win_s[7]}}, win_s[7:0]};
            MEM_OP_BU: ldata_o = {{(DATA_WIDTH-8){1'b0}}, win_s[7:0]};
            MEM_OP_H:  ldata_o = {{(DATA_WIDTH-16){win_s[15]}}, win_s[15:0]};
            MEM_OP_HU: ldata_o = {{(DATA_WIDTH-16){1'b0}}, win_s[15:0]};
            MEM_OP_W:  ldata_o = win_s;
            default:   ldata_o = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/rv_lsu_seq.sv
// Load/store sequencer: accepts one request from execute, issues one or two
// word-aligned bus beats (two when the access crosses a word boundary),
// assembles load data and pulses done for one cycle.
module rv_lsu_seq #(
    parameter int DATA_WIDTH = my_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic [2:0]            mem_op,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [DATA_WIDTH-1:0] dbus_addr,
    output logic [3:0]            dbus_be,
    output logic [DATA_WIDTH-1:0] dbus_wdata,
    input  logic                  dbus_gnt,
    input  logic                  dbus_rvalid,
    input  logic [DATA_WIDTH-1:0] dbus_rdata
);
    import my_pkg::*;

    lsu_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, beat0_q, rdata_q;
    logic [2:0]            op_q;
    logic                  store_q;

    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [DATA_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;

    logic                  accept_s, store_sel_s, split_s, load_done_s;
    logic [2:0]            op_sel_s;
    logic [DATA_WIDTH-1:0] addr_sel_s, wdata_sel_s, rdata0_sel_s;
    logic [3:0]            be0_s, be1_s;
    logic [DATA_WIDTH-1:0] wd0_s, wd1_s, ldata_s, base_s;

    assign accept_s = start && (state_q == ST_IDLE) && (mem_write || mem_to_reg)
                      && op_is_legal(mem_op);

    // On the accept cycle the live inputs drive the lane logic so beat 0 can
    // be registered in the same edge that latches the request.
    assign op_sel_s     = accept_s ? mem_op : op_q;
    assign addr_sel_s   = accept_s ? addr   : addr_q;
    assign wdata_sel_s  = accept_s ? wdata  : wdata_q;
    assign store_sel_s  = accept_s ? mem_write : store_q;
    assign rdata0_sel_s = (state_q == ST_RSP1) ? beat0_q : dbus_rdata;
    assign base_s       = {addr_q[DATA_WIDTH-1:2], 2'b00};

    rv_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .op_i     (op_sel_s),
        .off_i    (addr_sel_s[1:0]),
        .wdata_i  (wdata_sel_s),
        .rdata0_i (rdata0_sel_s),
        .rdata1_i (dbus_rdata),
        .split_o  (split_s),
        .be0_o    (be0_s),
        .be1_o    (be1_s),
        .wdata0_o (wd0_s),
        .wdata1_o (wd1_s),
        .ldata_o  (ldata_s)
    );

    assign load_done_s = !store_q && dbus_rvalid
                         && (((state_q == ST_RSP0) && !split_s) || (state_q == ST_RSP1));

    // State register, request latches, beat-0 read capture and load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= {DATA_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
            beat0_q     <= {DATA_WIDTH{1'b0}};
            rdata_q     <= {DATA_WIDTH{1'b0}};
            op_q        <= 3'b000;
            store_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= {DATA_WIDTH{1'b0}};
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            if (accept_s) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                op_q    <= mem_op;
                store_q <= mem_write;
            end
            if ((state_q == ST_RSP0) && dbus_rvalid) begin
                beat0_q <= dbus_rdata;
            end
            if (load_done_s) begin
                rdata_q <= ldata_s;
            end
        end
    end

    // Next-state: one or two request/response beats, then a single DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_REQ0;
                else          state_d = ST_IDLE;
            end
            ST_REQ0: begin
                if (dbus_gnt) state_d = ST_RSP0;
                else          state_d = ST_REQ0;
            end
            ST_RSP0: begin
                if (dbus_rvalid && split_s)  state_d = ST_REQ1;
                else if (dbus_rvalid)        state_d = ST_DONE;
                else                         state_d = ST_RSP0;
            end
            ST_REQ1: begin
                if (dbus_gnt) state_d = ST_RSP1;
                else          state_d = ST_REQ1;
            end
            ST_RSP1: begin
                if (dbus_rvalid) state_d = ST_DONE;
                else             state_d = ST_RSP1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered bus outputs, keyed on the coming state.
    always_comb begin
        bus_req_d   = 1'b0;
        bus_we_d    = 1'b0;
        bus_be_d    = 4'b0000;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if ((state_q == ST_IDLE) && (state_d == ST_REQ0)) begin
            bus_req_d   = 1'b1;
            bus_we_d    = store_sel_s;
            bus_addr_d  = {addr_sel_s[DATA_WIDTH-1:2], 2'b00};
            bus_be_d    = be0_s;
            bus_wdata_d = wd0_s;
        end else if ((state_q == ST_RSP0) && (state_d == ST_REQ1)) begin
            bus_req_d   = 1'b1;
            bus_we_d    = store_q;
            bus_addr_d  = base_s + {{(DATA_WIDTH-3){1'b0}}, 3'b100};
            bus_be_d    = be1_s;
            bus_wdata_d = wd1_s;
        end else if ((state_d == ST_REQ0) || (state_d == ST_REQ1)) begin
            bus_req_d   = 1'b1;
            bus_we_d    = bus_we_q;
            bus_be_d    = bus_be_q;
        end else begin
            bus_req_d   = 1'b0;
            bus_be_d    = 4'b0000;
        end
    end

    assign busy       = accept_s || ((state_q != ST_IDLE) && (state_q != ST_DONE));
    assign done       = (state_q == ST_DONE);
    assign rdata      = rdata_q;
    assign dbus_req   = bus_req_q;
    assign dbus_we    = bus_we_q;
    assign dbus_addr  = bus_addr_q;
    assign dbus_be    = bus_be_q;
    assign dbus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_rv_lsu_seq.sv
// Bench for rv_lsu_seq: byte-addressed memory responder with configurable
// grant/response delays, byte-level reference model for loads and stores.
module tb_rv_lsu_seq;

    logic        clk = 1'b0;
    logic        rst, start, mem_write, mem_to_reg;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata, rdata, dbus_addr, dbus_wdata, dbus_rdata;
    logic        busy, done, dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
    logic [3:0]  dbus_be;

    always #5 clk = ~clk;

    rv_lsu_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .mem_op(mem_op), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .dbus_req(dbus_req),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
        .dbus_rdata(dbus_rdata)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mem [int unsigned];
    logic [31:0] exp_rdata;

    int          n_beats, done_cyc;
    logic [31:0] b_addr [2];
    logic [3:0]  b_be   [2];
    logic        b_we   [2];
    logic [31:0] b_wd   [2];
    bit          unstable, stray_be, busy_err, extra_act;

    function automatic logic [7:0] rb(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        else               return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int op_size(input logic [2:0] op);
        if (op[1:0] == 2'b01)      return 1;
        else if (op[1:0] == 2'b10) return 2;
        else                       return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] v;
        int sz;
        sz = op_size(op);
        v  = 32'h0;
        for (int i = 0; i < sz; i++) v = v | ({24'h0, rb(a + 32'(i))} << (8 * i));
        if (!op[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] op, input logic [31:0] a, input int beat);
        logic [3:0]  be;
        logic [31:0] ab;
        be = 4'h0;
        for (int i = 0; i < op_size(op); i++) begin
            ab = a + 32'(i);
            if (((ab >> 2) != (a >> 2)) == (beat == 1)) be[ab[1:0]] = 1'b1;
        end
        return be;
    endfunction

    function automatic int ref_beats(input logic [2:0] op, input logic [31:0] a);
        return (int'(a[1:0]) + op_size(op) > 4) ? 2 : 1;
    endfunction

    // Drive one request and act as the bus slave until done (bounded).
    task automatic run_op(input logic w, input logic r, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int gdly, input int rdly, input bit hold_start);
        int gcnt, rcnt;
        bit in_req, rpend;
        logic [31:0] last_a;
        n_beats = 0; done_cyc = -1; unstable = 0; stray_be = 0; busy_err = 0; extra_act = 0;
        in_req = 0; rpend = 0; gcnt = 0; rcnt = 0; last_a = 32'h0;
        @(negedge clk);
        start = 1'b1; mem_write = w; mem_to_reg = r; mem_op = op; addr = a; wdata = wd;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
        #1;
        if (!busy) busy_err = 1;
        for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start = hold_start; mem_write = 1'b0; mem_to_reg = 1'b1; mem_op = 3'b011;
            addr = $urandom; wdata = $urandom;
            dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = $urandom;
            if (done) begin
                done_cyc = cyc;
                if (busy) busy_err = 1;
            end else begin
                if (!busy) busy_err = 1;
                if (dbus_req) begin
                    if (!in_req) begin
                        in_req = 1; gcnt = 0;
                        if (n_beats < 2) begin
                            b_addr[n_beats] = dbus_addr; b_be[n_beats] = dbus_be;
                            b_we[n_beats] = dbus_we; b_wd[n_beats] = dbus_wdata;
                        end
                    end else if (n_beats < 2 && (dbus_addr !== b_addr[n_beats] || dbus_be !== b_be[n_beats]
                               || dbus_we !== b_we[n_beats] || dbus_wdata !== b_wd[n_beats])) begin
                        unstable = 1;
                    end
                    if (gcnt == gdly) begin
                        dbus_gnt = 1'b1; in_req = 0; rpend = 1; rcnt = rdly; last_a = dbus_addr;
                        if (dbus_we)
                            for (int l = 0; l < 4; l++)
                                if (dbus_be[l]) mem[dbus_addr + 32'(l)] = dbus_wdata[8*l +: 8];
                        n_beats++;
                    end else begin
                        gcnt++;
                    end
                end else begin
                    if (dbus_be !== 4'h0) stray_be = 1;
                    if (rpend) begin
                        if (rcnt == 0) begin
                            dbus_rvalid = 1'b1; rpend = 0;
                            dbus_rdata = {rb(last_a + 32'd3), rb(last_a + 32'd2), rb(last_a + 32'd1), rb(last_a)};
                        end else begin
                            rcnt--;
                        end
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
            #1;
            if (dbus_req || done || busy) extra_act = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; mem_op = 3'b000;
        addr = 32'h0; wdata = 32'h0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, dbus_req, dbus_we, dbus_be} !== 8'h00) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=00000000", {busy, done, dbus_req, dbus_we, dbus_be});
        end
        total++;
        if ({rdata, dbus_addr, dbus_wdata} !== 96'h0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", rdata, dbus_addr, dbus_wdata);
        end
        rst = 1'b0;
        exp_rdata = 32'h0;
    endtask

    task automatic test_lw();
        mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
        run_op(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 0, 0, 1'b0);
        total++;
        if (done_cyc !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", done_cyc); end
        total++;
        if (n_beats !== 1 || b_be[0] !== 4'b1111 || b_addr[0] !== 32'h100 || b_we[0] !== 1'b0) begin
            bad++; $display("FAIL lw_beat got=%0d/%b/%h exp=1/1111/100", n_beats, b_be[0], b_addr[0]);
        end
        total++;
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", rdata); end
        exp_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_lb();
        mem[32'h100] = 8'hFF; mem[32'h101] = 8'hFF; mem[32'h102] = 8'hFF; mem[32'h103] = 8'h80;
        run_op(1'b0, 1'b1, 3'b001, 32'h103, 32'h0, 0, 0, 1'b0);
        total++;
        if (b_be[0] !== 4'b1000 || n_beats !== 1) begin
            bad++; $display("FAIL lb_be got=%b/%0d exp=1000/1", b_be[0], n_beats);
        end
        total++;
        if (rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_rdata got=%h exp=ffffff80", rdata); end
        run_op(1'b0, 1'b1, 3'b101, 32'h103, 32'h0, 0, 0, 1'b0);
        total++;
        if (rdata !== 32'h00000080) begin bad++; $display("FAIL lbu_rdata got=%h exp=00000080", rdata); end
        exp_rdata = 32'h00000080;
    endtask

    task automatic test_sw_split();
        run_op(1'b1, 1'b0, 3'b011, 32'h102, 32'h11223344, 0, 0, 1'b0);
        total++;
        if (done_cyc !== 5) begin bad++; $display("FAIL sw_latency got=%0d exp=5", done_cyc); end
        total++;
        if (n_beats !== 2 || b_addr[0] !== 32'h100 || b_be[0] !== 4'b1100 || b_wd[0][31:16] !== 16'h3344
            || b_we[0] !== 1'b1) begin
            bad++; $display("FAIL sw_beat0 got=%h/%b/%h exp=100/1100/3344xxxx", b_addr[0], b_be[0], b_wd[0]);
        end
        total++;
        if (b_addr[1] !== 32'h104 || b_be[1] !== 4'b0011 || b_wd[1][15:0] !== 16'h1122 || b_we[1] !== 1'b1) begin
            bad++; $display("FAIL sw_beat1 got=%h/%b/%h exp=104/0011/xxxx1122", b_addr[1], b_be[1], b_wd[1]);
        end
        total++;
        if ({rb(32'h105), rb(32'h104), rb(32'h103), rb(32'h102)} !== 32'h11223344) begin
            bad++; $display("FAIL sw_mem got=%h%h%h%h exp=11223344", rb(32'h105), rb(32'h104), rb(32'h103), rb(32'h102));
        end
        total++;
        if (rdata !== exp_rdata) begin bad++; $display("FAIL sw_rdata_hold got=%h exp=%h", rdata, exp_rdata); end
    endtask

    task automatic test_lh_delay();
        mem[32'h203] = 8'hCD; mem[32'h204] = 8'h9A;
        run_op(1'b0, 1'b1, 3'b010, 32'h203, 32'h0, 3, 0, 1'b0);
        total++;
        if (unstable || stray_be || busy_err) begin
            bad++; $display("FAIL lh_stable got=%0d%0d%0d exp=000", unstable, stray_be, busy_err);
        end
        total++;
        if (done_cyc !== 11 || n_beats !== 2) begin
            bad++; $display("FAIL lh_latency got=%0d/%0d exp=11/2", done_cyc, n_beats);
        end
        total++;
        if (rdata !== 32'hFFFF9ACD) begin bad++; $display("FAIL lh_rdata got=%h exp=ffff9acd", rdata); end
        exp_rdata = 32'hFFFF9ACD;
    endtask

    task automatic test_ignore();
        logic [4:0] cases [4];
        bit act;
        cases[0] = {2'b01, 3'b000}; cases[1] = {2'b01, 3'b111};
        cases[2] = {2'b10, 3'b100}; cases[3] = {2'b00, 3'b011};
        for (int c = 0; c < 4; c++) begin
            act = 0;
            @(negedge clk);
            start = 1'b1; mem_write = cases[c][4]; mem_to_reg = cases[c][3]; mem_op = cases[c][2:0];
            addr = 32'h100;
            #1;
            if (busy) act = 1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (dbus_req || done || busy) act = 1;
            end
            total++;
            if (act) begin bad++; $display("FAIL ignore_illegal case=%0d got=active exp=idle", c); end
        end
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        run_op(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 1, 1, 1'b1);
        total++;
        if (n_beats !== 1 || extra_act || done_cyc !== 5) begin
            bad++; $display("FAIL ignore_busy_done got=%0d/%0d/%0d exp=1/0/5", n_beats, extra_act, done_cyc);
        end
        total++;
        if (rdata !== 32'h12345678) begin bad++; $display("FAIL ignore_rdata got=%h exp=12345678", rdata); end
    endtask

    task automatic test_abort();
        bit act;
        act = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_rdata = 32'h0;
        start = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1; mem_op = 3'b011; addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (dbus_req !== 1'b1) begin bad++; $display("FAIL abort_req got=%b exp=1", dbus_req); end
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFEF00D;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dbus_rvalid = 1'b0;
            if (done || dbus_req || busy) act = 1;
        end
        total++;
        if (act) begin bad++; $display("FAIL abort_idle got=active exp=idle"); end
        total++;
        if (rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata got=%h exp=0", rdata); end
    endtask

    task automatic test_random();
        logic [2:0]  legal [5];
        logic [2:0]  op;
        logic [31:0] a, wd, exp_v, got_w, exp_w;
        logic [7:0]  lo_b, hi_b;
        logic        w, r;
        int gd, rd, nb, sz;
        legal[0] = 3'b001; legal[1] = 3'b010; legal[2] = 3'b011; legal[3] = 3'b101; legal[4] = 3'b110;
        for (int it = 0; it < 40; it++) begin
            op = legal[$urandom_range(0, 4)];
            w  = 1'($urandom_range(0, 1));
            r  = w ? 1'($urandom_range(0, 1)) : 1'b1;
            a  = 32'h300 + 32'($urandom_range(0, 63));
            wd = $urandom; gd = $urandom_range(0, 2); rd = $urandom_range(0, 2);
            sz = op_size(op); nb = ref_beats(op, a);
            exp_v = ref_load(op, a);
            lo_b = rb(a - 32'd1); hi_b = rb(a + 32'(sz));
            run_op(w, r, op, a, wd, gd, rd, 1'b0);
            total++;
            if (done_cyc !== nb * (gd + rd + 2) + 1 || n_beats !== nb) begin
                bad++; $display("FAIL rnd_timing it=%0d got=%0d/%0d exp=%0d/%0d", it, done_cyc, n_beats,
                                nb * (gd + rd + 2) + 1, nb);
            end
            total++;
            if (b_addr[0] !== {a[31:2], 2'b00} || b_be[0] !== ref_be(op, a, 0) || b_we[0] !== w) begin
                bad++; $display("FAIL rnd_beat0 it=%0d got=%h/%b/%b exp=%h/%b/%b", it, b_addr[0], b_be[0], b_we[0],
                                {a[31:2], 2'b00}, ref_be(op, a, 0), w);
            end
            if (nb == 2) begin
                total++;
                if (b_addr[1] !== {a[31:2], 2'b00} + 32'd4 || b_be[1] !== ref_be(op, a, 1)) begin
                    bad++; $display("FAIL rnd_beat1 it=%0d got=%h/%b exp=%h/%b", it, b_addr[1], b_be[1],
                                    {a[31:2], 2'b00} + 32'd4, ref_be(op, a, 1));
                end
            end
            total++;
            if (unstable || stray_be || busy_err || extra_act) begin
                bad++; $display("FAIL rnd_proto it=%0d got=%0d%0d%0d%0d exp=0000", it, unstable, stray_be,
                                busy_err, extra_act);
            end
            if (w) begin
                got_w = 32'h0; exp_w = 32'h0;
                for (int i = 0; i < sz; i++) begin
                    got_w = got_w | ({24'h0, rb(a + 32'(i))} << (8 * i));
                    exp_w = exp_w | ({24'h0, wd[8*i +: 8]} << (8 * i));
                end
                total++;
                if (got_w !== exp_w || rb(a - 32'd1) !== lo_b || rb(a + 32'(sz)) !== hi_b) begin
                    bad++; $display("FAIL rnd_store it=%0d got=%h exp=%h", it, got_w, exp_w);
                end
            end else begin
                exp_rdata = exp_v;
            end
            total++;
            if (rdata !== exp_rdata) begin
                bad++; $display("FAIL rnd_rdata it=%0d got=%h exp=%h", it, rdata, exp_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sw_split();
        test_lh_delay();
        test_ignore();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
